// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame link (transmit and receive sides).
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;

  // One counter covers both the data bits and the guard bits, so size it for the larger.
  function automatic int bit_cnt_w(input int data_w, input int gap_bits);
    int n;
    n = (data_w > gap_bits) ? data_w : gap_bits;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int div_cnt_w(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

  function automatic logic even_parity(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period divider: emits a one-cycle bit_end tick every CLK_DIV cycles, restartable.
module serial_bit_timer
  import serial_frame_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int W = div_cnt_w(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  // With CLK_DIV=1 the counter never leaves zero and bit_end is permanently high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (restart || bit_end)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter with a one-word holding register for gapless frames.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1,
  parameter int GAP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              start,
  output logic              dout,
  output logic              busy
);

  localparam int BW = bit_cnt_w(DATA_W, GAP_BITS);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_GAP  = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_t            state, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
  logic [DATA_W-1:0] load_word;
  logic              hold_full, hold_full_next;
  logic              par_bit, par_next;
  logic              ready_reg;
  logic [BW-1:0]     bit_idx, bit_idx_next;
  logic              hs, bit_end, load, frame_end;

  assign hs       = tx_valid && ready_reg;
  assign tx_ready = ready_reg;

  serial_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(load),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      par_bit   <= 1'b0;
      bit_idx   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      hold_reg  <= hold_next;
      hold_full <= hold_full_next;
      par_bit   <= par_next;
      bit_idx   <= bit_idx_next;
      ready_reg <= !hold_full_next;
    end
  end

  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full;
    par_next       = par_bit;
    bit_idx_next   = bit_idx;
    load_word      = tx_data;
    load           = 1'b0;
    frame_end      = 1'b0;

    case (state)
      IDLE: if (hs) load = 1'b1;
      DATA: if (bit_end) begin
        if (bit_idx == LAST_DATA) begin
          bit_idx_next = '0;
          if (PARITY_EN)         state_next = PARITY;
          else if (GAP_BITS > 0) state_next = GAP;
          else                   frame_end  = 1'b1;
        end else begin
          bit_idx_next = bit_idx + 1'b1;
          shift_next   = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
        end
      end
      PARITY: if (bit_end) begin
        if (GAP_BITS > 0) state_next = GAP;
        else              frame_end  = 1'b1;
      end
      GAP: if (bit_end) begin
        if (bit_idx == LAST_GAP) frame_end    = 1'b1;
        else                     bit_idx_next = bit_idx + 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // A word arriving exactly at end-of-frame with nothing held bypasses the holding register.
    if (frame_end) begin
      if (hold_full) begin
        load           = 1'b1;
        load_word      = hold_reg;
        hold_full_next = 1'b0;
      end else if (hs) begin
        load = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end else if (hs && state != IDLE) begin
      hold_next      = tx_data;
      hold_full_next = 1'b1;
    end

    if (load) begin
      state_next   = DATA;
      shift_next   = load_word;
      bit_idx_next = '0;
      par_next     = even_parity(64'(load_word));
    end
  end

  always_comb begin
    start = 1'b0;
    dout  = 1'b0;
    busy  = (state != IDLE);
    case (state)
      DATA: begin
        start = (bit_idx == '0);
        dout  = MSB_FIRST ? shift_reg[DATA_W-1] : shift_reg[0];
      end
      PARITY:  dout = par_bit;
      default: dout = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default, LSB-first and fast (CLK_DIV=1, bare) configurations.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] d0_data = '0, d1_data = '0, d2_data = '0;
  logic       d0_valid = 1'b0, d1_valid = 1'b0, d2_valid = 1'b0;
  logic       d0_ready, d0_start, d0_dout, d0_busy;
  logic       d1_ready, d1_start, d1_dout, d1_busy;
  logic       d2_ready, d2_start, d2_dout, d2_busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_frame_tx dut (
    .clk(clk), .rst(rst), .tx_data(d0_data), .tx_valid(d0_valid), .tx_ready(d0_ready),
    .start(d0_start), .dout(d0_dout), .busy(d0_busy)
  );

  serial_frame_tx #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .tx_data(d1_data), .tx_valid(d1_valid), .tx_ready(d1_ready),
    .start(d1_start), .dout(d1_dout), .busy(d1_busy)
  );

  serial_frame_tx #(.CLK_DIV(1), .PARITY_EN(1'b0), .GAP_BITS(0)) dut_fast (
    .clk(clk), .rst(rst), .tx_data(d2_data), .tx_valid(d2_valid), .tx_ready(d2_ready),
    .start(d2_start), .dout(d2_dout), .busy(d2_busy)
  );

  // Bit at position pos of an 8-data + parity + 1-gap frame.
  function automatic logic frame_bit(input logic [7:0] w, input int pos, input bit msb);
    if (pos < 8) return msb ? w[7-pos] : w[pos];
    if (pos == 8) return ^w;
    return 1'b0;
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {d0_ready, d0_start, d0_dout, d0_busy};
    total++;
    if (got !== 4'b0000) $display("FAIL reset_outputs: got %b expected 0000", got);
    else passed++;
    got = {d2_ready, d2_start, d2_dout, d2_busy};
    total++;
    if (got !== 4'b0000) $display("FAIL reset_outputs_fast: got %b expected 0000", got);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (d0_ready !== 1'b0) $display("FAIL ready_before_edge: got %b expected 0", d0_ready);
    else passed++;
    @(negedge clk);
    got = {1'b0, d0_ready, d1_ready, d2_ready};
    total++;
    if (got !== 4'b0111) $display("FAIL ready_after_release: got %b expected 0111", got);
    else passed++;
  endtask

  task automatic test_single_a5();
    logic [2:0] got, exp;
    d0_data  = 8'hA5;
    d0_valid = 1'b1;
    @(negedge clk);
    d0_valid = 1'b0;
    d0_data  = 8'h00;
    for (int c = 1; c <= 41; c++) begin
      exp = (c <= 40) ? {(c <= 4), frame_bit(8'hA5, (c - 1) / 4, 1'b1), 1'b1} : 3'b000;
      got = {d0_start, d0_dout, d0_busy};
      total++;
      if (got !== exp) $display("FAIL a5_frame cycle %0d: got start/dout/busy %b expected %b", c, got, exp);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_lsb_07();
    logic [2:0] got, exp;
    d1_data  = 8'h07;
    d1_valid = 1'b1;
    @(negedge clk);
    d1_valid = 1'b0;
    d1_data  = 8'h00;
    for (int c = 1; c <= 41; c++) begin
      exp = (c <= 40) ? {(c <= 4), frame_bit(8'h07, (c - 1) / 4, 1'b0), 1'b1} : 3'b000;
      got = {d1_start, d1_dout, d1_busy};
      total++;
      if (got !== exp) $display("FAIL lsb_07_frame cycle %0d: got start/dout/busy %b expected %b", c, got, exp);
      else passed++;
      @(negedge clk);
    end
  endtask

  // Keeps tx_valid high and scrambles tx_data whenever tx_ready is low.
  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic [7:0] w;
    logic [3:0] got, exp;
    logic       prev_ready;
    int         idx, fc;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    idx = 0;
    d0_valid = 1'b1;
    d0_data  = words[0];
    prev_ready = d0_ready;
    for (int c = 1; c <= 121; c++) begin
      @(negedge clk);
      if (d0_valid && prev_ready) idx++;
      if (idx < 3) begin
        d0_valid = 1'b1;
        d0_data  = d0_ready ? words[idx] : (8'hE0 ^ 8'(c));
      end else begin
        d0_valid = 1'b0;
        d0_data  = 8'h00;
      end
      w  = (c <= 40) ? 8'h01 : (c <= 80) ? 8'h02 : 8'h03;
      fc = (c - 1) % 40;
      exp = (c <= 120) ? {(fc < 4), frame_bit(w, fc / 4, 1'b1), 1'b1, 1'b0} : 4'b0000;
      exp[0] = (c == 1) || (c == 41) || (c >= 81);
      got = {d0_start, d0_dout, d0_busy, d0_ready};
      total++;
      if (got !== exp) $display("FAIL b2b cycle %0d: got start/dout/busy/ready %b expected %b", c, got, exp);
      else passed++;
      prev_ready = d0_ready;
    end
    total++;
    if (idx !== 3) $display("FAIL b2b_words_accepted: got %0d expected 3", idx);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [3:0] got;
    d0_data  = 8'h5A;
    d0_valid = 1'b1;
    @(negedge clk);
    d0_data = 8'hC3;
    @(negedge clk);
    d0_valid = 1'b0;
    d0_data  = 8'h00;
    repeat (15) @(negedge clk);
    got = {1'b0, d0_busy, d0_ready, d0_dout};
    total++;
    if (got !== 4'b0101) $display("FAIL abort_precheck: got busy/ready/dout %b expected 101", got[2:0]);
    else passed++;
    rst = 1'b1;
    #1;
    got = {d0_start, d0_dout, d0_busy, d0_ready};
    total++;
    if (got !== 4'b0000) $display("FAIL abort_immediate: got %b expected 0000", got);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (d0_ready !== 1'b0) $display("FAIL abort_ready_low: got %b expected 0", d0_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (d0_ready !== 1'b1) $display("FAIL abort_ready_high: got %b expected 1", d0_ready);
    else passed++;
    for (int c = 0; c < 60; c++) begin
      got = {1'b0, d0_start, d0_dout, d0_busy};
      total++;
      if (got !== 4'b0000) $display("FAIL abort_residual cycle %0d: got %b expected 0000", c, got);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_fast();
    logic [3:0] got, exp;
    d2_data  = 8'hFF;
    d2_valid = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) d2_data = 8'h00;
      if (c == 2) d2_valid = 1'b0;
      exp = {(c == 1) || (c == 9), (c <= 8), (c <= 16), (c == 1) || (c >= 9)};
      got = {d2_start, d2_dout, d2_busy, d2_ready};
      total++;
      if (got !== exp) $display("FAIL fast cycle %0d: got start/dout/busy/ready %b expected %b", c, got, exp);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_lsb_07();
    test_back_to_back();
    test_reset_abort();
    test_fast();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
